// File: rtl/id_stage_pipe_pkg.sv
// Shared decode-stage definitions: opcode map, default implicit registers and
// the small select encodings passed from the decoder to the operand muxes.
package id_stage_pipe_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_SUB  = 4'h1,
    OP_NAND = 4'h2,
    OP_XOR  = 4'h3,
    OP_INC  = 4'h4,
    OP_SRA  = 4'h5,
    OP_SRL  = 4'h6,
    OP_SLL  = 4'h7,
    OP_SW   = 4'h8,
    OP_LW   = 4'h9,
    OP_LHB  = 4'hA,
    OP_LLB  = 4'hB,
    OP_B    = 4'hC,
    OP_CALL = 4'hD,
    OP_RET  = 4'hE,
    OP_ILL  = 4'hF
  } opcode_e;

  localparam int DS_REG_DEF = 14;
  localparam int SP_REG_DEF = 15;

  typedef enum logic {
    A1_ZERO,
    A1_S0
  } alu1_sel_e;

  typedef enum logic [1:0] {
    A2_ZERO,
    A2_S1,
    A2_IMM
  } alu2_sel_e;

  typedef enum logic [1:0] {
    DST_NONE,
    DST_RD,
    DST_SP
  } dest_e;

endpackage

// File: rtl/id_stage_pipe_decode.sv
// Combinational instruction decoder: source addresses and use flags, operand
// selects, extended immediate, destination and illegal-opcode detection.
module id_stage_pipe_decode
  import id_stage_pipe_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int RF_ADDR_W = 4,
  parameter int DS_REG    = DS_REG_DEF,
  parameter int SP_REG    = SP_REG_DEF
) (
  input  logic [15:0]          instr,
  output logic [RF_ADDR_W-1:0] s0_addr,
  output logic [RF_ADDR_W-1:0] s1_addr,
  output logic                 s0_used,
  output logic                 s1_used,
  output alu1_sel_e            alu1_sel,
  output alu2_sel_e            alu2_sel,
  output logic [DATA_W-1:0]    imm,
  output logic [RF_ADDR_W-1:0] rd,
  output logic                 wr,
  output logic                 illegal
);

  localparam logic [RF_ADDR_W-1:0] DS_ADDR = RF_ADDR_W'(DS_REG);
  localparam logic [RF_ADDR_W-1:0] SP_ADDR = RF_ADDR_W'(SP_REG);

  logic [RF_ADDR_W-1:0] f_hi, f_mid, f_lo;
  dest_e                dst;

  assign f_hi  = RF_ADDR_W'(instr[11:8]);
  assign f_mid = RF_ADDR_W'(instr[7:4]);
  assign f_lo  = RF_ADDR_W'(instr[3:0]);

  always_comb begin
    s0_addr  = '0;
    s1_addr  = '0;
    s0_used  = 1'b0;
    s1_used  = 1'b0;
    alu1_sel = A1_ZERO;
    alu2_sel = A2_ZERO;
    imm      = '0;
    dst      = DST_NONE;
    illegal  = 1'b0;
    unique case (opcode_e'(instr[15:12]))
      OP_ADD, OP_SUB, OP_NAND, OP_XOR: begin
        s0_addr  = f_mid;  s0_used = 1'b1;
        s1_addr  = f_lo;   s1_used = 1'b1;
        alu1_sel = A1_S0;  alu2_sel = A2_S1;
        dst      = DST_RD;
      end
      OP_INC: begin
        s0_addr  = f_mid;  s0_used = 1'b1;
        alu1_sel = A1_S0;  alu2_sel = A2_IMM;
        imm      = {{(DATA_W-4){instr[3]}}, instr[3:0]};
        dst      = DST_RD;
      end
      OP_SRA, OP_SRL, OP_SLL: begin
        s0_addr  = f_mid;  s0_used = 1'b1;
        alu1_sel = A1_S0;  alu2_sel = A2_IMM;
        imm      = DATA_W'(instr[3:0]);
        dst      = DST_RD;
      end
      OP_SW: begin
        s0_addr  = f_hi;    s0_used = 1'b1;
        s1_addr  = DS_ADDR; s1_used = 1'b1;
        alu1_sel = A1_S0;   alu2_sel = A2_S1;
      end
      OP_LW: begin
        s1_addr  = DS_ADDR; s1_used = 1'b1;
        alu2_sel = A2_S1;
        dst      = DST_RD;
      end
      OP_LHB, OP_LLB: begin
        s0_addr  = f_hi;   s0_used = 1'b1;
        alu1_sel = A1_S0;  alu2_sel = A2_IMM;
        imm      = DATA_W'(instr[7:0]);
        dst      = DST_RD;
      end
      OP_B: begin
        alu2_sel = A2_IMM;
        imm      = {{(DATA_W-8){instr[7]}}, instr[7:0]};
      end
      OP_CALL, OP_RET: begin
        s0_addr  = SP_ADDR; s0_used = 1'b1;
        alu1_sel = A1_S0;   alu2_sel = A2_IMM;
        imm      = DATA_W'(1);
        dst      = DST_SP;
      end
      default: illegal = 1'b1;
    endcase

    // Non-writing instructions report rd=0 so EX never sees a stale address.
    unique case (dst)
      DST_RD:  rd = f_hi;
      DST_SP:  rd = SP_ADDR;
      default: rd = '0;
    endcase
    wr = (dst != DST_NONE);
  end

endmodule

// File: rtl/id_stage_pipe.sv
// Registered decode stage: RF read, EX/MEM forwarding, load-use hazard stall
// and valid/ready handshakes towards IF and EX.
module id_stage_pipe
  import id_stage_pipe_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int RF_ADDR_W = 4,
  parameter int DS_REG    = DS_REG_DEF,
  parameter int SP_REG    = SP_REG_DEF,
  parameter int FWD_EN    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 if_valid,
  output logic                 if_ready,
  input  logic [15:0]          if_instr,
  input  logic                 flush,
  output logic [RF_ADDR_W-1:0] rf_p0_addr,
  output logic [RF_ADDR_W-1:0] rf_p1_addr,
  input  logic [DATA_W-1:0]    rf_p0_data,
  input  logic [DATA_W-1:0]    rf_p1_data,
  input  logic                 ex_fwd_en,
  input  logic [RF_ADDR_W-1:0] ex_fwd_addr,
  input  logic [DATA_W-1:0]    ex_fwd_data,
  input  logic                 mem_fwd_en,
  input  logic [RF_ADDR_W-1:0] mem_fwd_addr,
  input  logic [DATA_W-1:0]    mem_fwd_data,
  output logic                 ex_valid,
  input  logic                 ex_ready,
  output logic [3:0]           ex_opcode,
  output logic [RF_ADDR_W-1:0] ex_rd,
  output logic                 ex_wr,
  output logic [DATA_W-1:0]    ex_alu1,
  output logic [DATA_W-1:0]    ex_alu2,
  output logic                 ex_illegal
);

  logic [RF_ADDR_W-1:0] s0_addr, s1_addr, dec_rd;
  logic                 s0_used, s1_used, dec_wr, dec_illegal;
  alu1_sel_e            alu1_sel;
  alu2_sel_e            alu2_sel;
  logic [DATA_W-1:0]    dec_imm;

  id_stage_pipe_decode #(
    .DATA_W   (DATA_W),
    .RF_ADDR_W(RF_ADDR_W),
    .DS_REG   (DS_REG),
    .SP_REG   (SP_REG)
  ) u_decode (
    .instr   (if_instr),
    .s0_addr (s0_addr),
    .s1_addr (s1_addr),
    .s0_used (s0_used),
    .s1_used (s1_used),
    .alu1_sel(alu1_sel),
    .alu2_sel(alu2_sel),
    .imm     (dec_imm),
    .rd      (dec_rd),
    .wr      (dec_wr),
    .illegal (dec_illegal)
  );

  assign rf_p0_addr = s0_addr;
  assign rf_p1_addr = s1_addr;

  logic                 ex_valid_q, ex_valid_d;
  logic [3:0]           ex_opcode_q, ex_opcode_d;
  logic [RF_ADDR_W-1:0] ex_rd_q, ex_rd_d;
  logic                 ex_wr_q, ex_wr_d;
  logic [DATA_W-1:0]    ex_alu1_q, ex_alu1_d;
  logic [DATA_W-1:0]    ex_alu2_q, ex_alu2_d;
  logic                 ex_illegal_q, ex_illegal_d;

  logic [1:0][RF_ADDR_W-1:0] src_addr;
  logic [1:0][DATA_W-1:0]    src_rf, src_val;
  logic [1:0]                src_used, load_use, raw_stall;
  logic                      held_load, stall, accept;

  assign src_addr  = {s1_addr, s0_addr};
  assign src_rf    = {rf_p1_data, rf_p0_data};
  assign src_used  = {s1_used, s0_used};
  assign held_load = ex_valid_q && (ex_opcode_q == OP_LW) && ex_wr_q;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      logic ex_hit, mem_hit;
      assign ex_hit       = src_used[gi] && ex_fwd_en  && (ex_fwd_addr  == src_addr[gi]);
      assign mem_hit      = src_used[gi] && mem_fwd_en && (mem_fwd_addr == src_addr[gi]);
      assign load_use[gi] = src_used[gi] && held_load && (ex_rd_q == src_addr[gi]);
      if (FWD_EN != 0) begin : g_fwd
        assign src_val[gi]   = ex_hit ? ex_fwd_data : (mem_hit ? mem_fwd_data : src_rf[gi]);
        assign raw_stall[gi] = 1'b0;
      end else begin : g_nofwd
        // Without bypass paths every pending write to a used source must drain first.
        assign src_val[gi]   = src_rf[gi];
        assign raw_stall[gi] = ex_hit || mem_hit;
      end
    end
  endgenerate

  assign stall    = (|load_use) || (|raw_stall);
  assign if_ready = !rst && !flush && !stall && (!ex_valid_q || ex_ready);
  assign accept   = if_valid && if_ready;

  always_comb begin
    ex_valid_d   = ex_valid_q;
    ex_opcode_d  = ex_opcode_q;
    ex_rd_d      = ex_rd_q;
    ex_wr_d      = ex_wr_q;
    ex_alu1_d    = ex_alu1_q;
    ex_alu2_d    = ex_alu2_q;
    ex_illegal_d = ex_illegal_q;
    if (flush) begin
      ex_valid_d = 1'b0;
    end else if (accept) begin
      ex_valid_d   = 1'b1;
      ex_opcode_d  = if_instr[15:12];
      ex_rd_d      = dec_rd;
      ex_wr_d      = dec_wr;
      ex_illegal_d = dec_illegal;
      ex_alu1_d    = (alu1_sel == A1_S0) ? src_val[0] : '0;
      unique case (alu2_sel)
        A2_S1:   ex_alu2_d = src_val[1];
        A2_IMM:  ex_alu2_d = dec_imm;
        default: ex_alu2_d = '0;
      endcase
    end else if (ex_ready) begin
      // Drained with nothing accepted (idle or stalled): present a bubble.
      ex_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_q   <= 1'b0;
      ex_opcode_q  <= '0;
      ex_rd_q      <= '0;
      ex_wr_q      <= 1'b0;
      ex_alu1_q    <= '0;
      ex_alu2_q    <= '0;
      ex_illegal_q <= 1'b0;
    end else begin
      ex_valid_q   <= ex_valid_d;
      ex_opcode_q  <= ex_opcode_d;
      ex_rd_q      <= ex_rd_d;
      ex_wr_q      <= ex_wr_d;
      ex_alu1_q    <= ex_alu1_d;
      ex_alu2_q    <= ex_alu2_d;
      ex_illegal_q <= ex_illegal_d;
    end
  end

  assign ex_valid   = ex_valid_q;
  assign ex_opcode  = ex_opcode_q;
  assign ex_rd      = ex_rd_q;
  assign ex_wr      = ex_wr_q;
  assign ex_alu1    = ex_alu1_q;
  assign ex_alu2    = ex_alu2_q;
  assign ex_illegal = ex_illegal_q;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed and randomized checks of id_stage_pipe against an opcode-level
// reference model of the decode stage.
module tb_id_stage_pipe;
  import id_stage_pipe_pkg::*;

  logic        clk;
  logic        rst;
  logic        if_valid, if_ready;
  logic [15:0] if_instr;
  logic        flush;
  logic [3:0]  rf_p0_addr, rf_p1_addr;
  logic [15:0] rf_p0_data, rf_p1_data;
  logic        ex_fwd_en, mem_fwd_en;
  logic [3:0]  ex_fwd_addr, mem_fwd_addr;
  logic [15:0] ex_fwd_data, mem_fwd_data;
  logic        ex_valid, ex_ready, ex_wr, ex_illegal;
  logic [3:0]  ex_opcode, ex_rd;
  logic [15:0] ex_alu1, ex_alu2;

  logic [15:0] rf_mem [16];
  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  assign rf_p0_data = rf_mem[rf_p0_addr];
  assign rf_p1_data = rf_mem[rf_p1_addr];

  id_stage_pipe dut (
    .clk(clk), .rst(rst),
    .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .flush(flush),
    .rf_p0_addr(rf_p0_addr), .rf_p1_addr(rf_p1_addr),
    .rf_p0_data(rf_p0_data), .rf_p1_data(rf_p1_data),
    .ex_fwd_en(ex_fwd_en), .ex_fwd_addr(ex_fwd_addr), .ex_fwd_data(ex_fwd_data),
    .mem_fwd_en(mem_fwd_en), .mem_fwd_addr(mem_fwd_addr), .mem_fwd_data(mem_fwd_data),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_opcode(ex_opcode), .ex_rd(ex_rd),
    .ex_wr(ex_wr), .ex_alu1(ex_alu1), .ex_alu2(ex_alu2), .ex_illegal(ex_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  op;
    logic        u0, u1;
    logic [3:0]  s0, s1, rd;
    logic        wr, ill;
    logic [15:0] a1, a2;
  } exp_t;

  // Value a source register should read as, given the current bypass inputs.
  function automatic logic [15:0] fwd(input logic [3:0] r);
    if (ex_fwd_en && ex_fwd_addr == r) return ex_fwd_data;
    if (mem_fwd_en && mem_fwd_addr == r) return mem_fwd_data;
    return rf_mem[r];
  endfunction

  function automatic exp_t model(input logic [15:0] ins);
    exp_t e;
    logic [3:0] a, b, c;
    logic [7:0] i8;
    a = ins[11:8]; b = ins[7:4]; c = ins[3:0]; i8 = ins[7:0];
    e = '0;
    e.op = ins[15:12];
    case (ins[15:12])
      OP_ADD, OP_SUB, OP_NAND, OP_XOR: begin
        e.u0 = 1; e.s0 = b; e.u1 = 1; e.s1 = c; e.rd = a; e.wr = 1;
        e.a1 = fwd(b); e.a2 = fwd(c);
      end
      OP_INC: begin
        e.u0 = 1; e.s0 = b; e.rd = a; e.wr = 1; e.a1 = fwd(b);
        e.a2 = (c >= 4'd8) ? 16'(32'(c) + 32'hFFF0) : 16'(c);
      end
      OP_SRA, OP_SRL, OP_SLL: begin
        e.u0 = 1; e.s0 = b; e.rd = a; e.wr = 1; e.a1 = fwd(b); e.a2 = 16'(c);
      end
      OP_SW: begin
        e.u0 = 1; e.s0 = a; e.u1 = 1; e.s1 = 4'd14; e.a1 = fwd(a); e.a2 = fwd(4'd14);
      end
      OP_LW: begin
        e.u1 = 1; e.s1 = 4'd14; e.rd = a; e.wr = 1; e.a1 = 16'h0; e.a2 = fwd(4'd14);
      end
      OP_LHB, OP_LLB: begin
        e.u0 = 1; e.s0 = a; e.rd = a; e.wr = 1; e.a1 = fwd(a); e.a2 = 16'(i8);
      end
      OP_B: e.a2 = (i8 >= 8'd128) ? 16'(32'(i8) + 32'hFF00) : 16'(i8);
      OP_CALL, OP_RET: begin
        e.u0 = 1; e.s0 = 4'd15; e.rd = 4'd15; e.wr = 1; e.a1 = fwd(4'd15); e.a2 = 16'd1;
      end
      default: e.ill = 1;
    endcase
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_fwd();
    ex_fwd_en = 0; ex_fwd_addr = 0; ex_fwd_data = 0;
    mem_fwd_en = 0; mem_fwd_addr = 0; mem_fwd_data = 0;
  endtask

  function automatic logic [3:0] pick_addr(input logic [15:0] ins);
    case ($urandom_range(0, 4))
      0: return ins[11:8];
      1: return ins[7:4];
      2: return ins[3:0];
      3: return 4'(14 + $urandom_range(0, 1));
      default: return 4'($urandom_range(0, 15));
    endcase
  endfunction

  exp_t cur, he;
  bit   hv, stall_e, rdy_e;

  initial begin
    for (int i = 0; i < 16; i++) rf_mem[i] = 16'($urandom);
    rf_mem[2] = 16'h0005;
    rst = 1; if_valid = 0; if_instr = 0; flush = 0; ex_ready = 1;
    clear_fwd();

    // Reset
    cyc(); cyc();
    check("rst_if_ready", if_ready, 0);
    check("rst_ex_valid", ex_valid, 0);
    check("rst_ex_fields", {ex_opcode, ex_rd, ex_wr, ex_illegal}, 0);
    check("rst_ex_alu", {ex_alu1, ex_alu2}, 0);
    rst = 0;
    #1;
    check("post_rst_if_ready", if_ready, 1);

    // INC r3,r2,#-1
    if_valid = 1; if_instr = 16'h432F;
    #1;
    check("inc_p0_addr", rf_p0_addr, 2);
    check("inc_p1_addr", rf_p1_addr, 0);
    cyc();
    check("inc_valid", ex_valid, 1);
    check("inc_alu1", ex_alu1, 16'h0005);
    check("inc_alu2", ex_alu2, 16'hFFFF);
    check("inc_rd_wr", {ex_rd, ex_wr}, {4'd3, 1'b1});

    // ADD r1,r4,r5: EX bypass beats MEM bypass
    if_instr = 16'h0145;
    ex_fwd_en = 1; ex_fwd_addr = 4; ex_fwd_data = 16'h1234;
    mem_fwd_en = 1; mem_fwd_addr = 4; mem_fwd_data = 16'hAAAA;
    #1;
    check("add_p_addrs", {rf_p0_addr, rf_p1_addr}, {4'd4, 4'd5});
    cyc();
    check("add_alu1_exfwd", ex_alu1, 16'h1234);
    check("add_alu2_rf", ex_alu2, rf_mem[5]);
    clear_fwd();

    // LW r6 then ADD r7,r6,r2: one bubble, then MEM bypass
    if_instr = 16'h9600;
    cyc();
    check("lw_issued", {ex_valid, ex_opcode, ex_rd, ex_wr}, {1'b1, 4'h9, 4'd6, 1'b1});
    if_instr = 16'h0762;
    #1;
    check("lu_if_ready", if_ready, 0);
    cyc();
    check("lu_bubble", ex_valid, 0);
    mem_fwd_en = 1; mem_fwd_addr = 6; mem_fwd_data = 16'hBEEF;
    #1;
    check("lu_retry_ready", if_ready, 1);
    cyc();
    check("lu_add_issued", {ex_valid, ex_opcode}, {1'b1, 4'h0});
    check("lu_add_alu1", ex_alu1, 16'hBEEF);
    check("lu_add_alu2", ex_alu2, 16'h0005);
    clear_fwd();

    // Back-pressure from EX for three cycles
    ex_ready = 0; if_instr = 16'h3123;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("bp_if_ready", if_ready, 0);
      cyc();
      check("bp_hold", {ex_valid, ex_opcode, ex_alu1, ex_alu2}, {1'b1, 4'h0, 16'hBEEF, 16'h0005});
    end
    ex_ready = 1;
    #1;
    check("bp_release_ready", if_ready, 1);
    cyc();
    check("bp_xor_issued", {ex_valid, ex_opcode, ex_alu1, ex_alu2}, {1'b1, 4'h3, rf_mem[2], rf_mem[3]});

    // Flush during a load-use stall, then an illegal opcode
    if_instr = 16'h9600;
    cyc();
    if_instr = 16'h0762; flush = 1;
    #1;
    check("fl_if_ready", if_ready, 0);
    cyc();
    check("fl_valid", ex_valid, 0);
    flush = 0; if_valid = 0;
    cyc();
    check("fl_not_issued", ex_valid, 0);
    if_valid = 1; if_instr = 16'hF123;
    #1;
    check("ill_if_ready", if_ready, 1);
    cyc();
    check("ill_flags", {ex_valid, ex_illegal, ex_wr, ex_rd}, {1'b1, 1'b1, 1'b0, 4'd0});
    check("ill_operands", {ex_alu1, ex_alu2}, 0);

    // Known empty state before random traffic
    if_valid = 0; flush = 1;
    cyc();
    flush = 0;
    hv = 0; he = '0;

    for (int i = 0; i < 500; i++) begin
      rf_mem[$urandom_range(0, 15)] = 16'($urandom);
      if_instr   = 16'($urandom);
      if_valid   = ($urandom_range(0, 3) != 0);
      ex_ready   = ($urandom_range(0, 3) != 0);
      flush      = ($urandom_range(0, 9) == 0);
      ex_fwd_en  = $urandom_range(0, 1) == 1;
      ex_fwd_addr = pick_addr(if_instr);
      ex_fwd_data = 16'($urandom);
      mem_fwd_en  = $urandom_range(0, 1) == 1;
      mem_fwd_addr = pick_addr(if_instr);
      mem_fwd_data = 16'($urandom);
      #1;
      cur = model(if_instr);
      stall_e = hv && he.op == OP_LW && he.wr &&
                ((cur.u0 && cur.s0 == he.rd) || (cur.u1 && cur.s1 == he.rd));
      rdy_e = !flush && !stall_e && (!hv || ex_ready);
      check("rnd_if_ready", if_ready, rdy_e);
      check("rnd_p0_addr", rf_p0_addr, cur.u0 ? cur.s0 : 4'd0);
      check("rnd_p1_addr", rf_p1_addr, cur.u1 ? cur.s1 : 4'd0);
      if (flush) hv = 0;
      else if (if_valid && rdy_e) begin hv = 1; he = cur; end
      else if (ex_ready) hv = 0;
      cyc();
      check("rnd_ex_valid", ex_valid, hv);
      if (hv) begin
        check("rnd_ex_ctl", {ex_opcode, ex_rd, ex_wr, ex_illegal}, {he.op, he.rd, he.wr, he.ill});
        check("rnd_ex_alu", {ex_alu1, ex_alu2}, {he.a1, he.a2});
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
